// File: rtl/hpd_pkg.sv
// Shared types and helpers for the HotPlug Detect monitor.
// Holds the FSM state encoding and the microsecond-to-tick conversion.
package hpd_pkg;

    typedef enum logic [1:0] {
        UNPLUGGED   = 2'b00,
        DEBOUNCE    = 2'b01,
        CONNECTED   = 2'b10,
        LOW_MEASURE = 2'b11
    } hpd_state_e;

    // 64-bit arithmetic so large clock rates times long intervals cannot overflow.
    function automatic longint us_to_ticks(input longint clk_hz, input longint us);
        return (clk_hz * us) / longint'(1_000_000);
    endfunction

endpackage

// File: rtl/hpd_sync.sv
// Multi-flop synchroniser for a slow asynchronous pin; shared by the pin monitors.
// Output is the pin delayed by STAGES clocks, cleared asynchronously on reset.
module hpd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], pin};
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/hpd_monitor.sv
// HotPlug Detect monitor: debounces plug-in, classifies low excursions as
// glitch / IRQ_HPD / unqualified / unplug, and rate-limits granted IRQs.
module hpd_monitor
    import hpd_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000,
    parameter int PLUG_US        = 100_000,
    parameter int IRQ_MIN_US     = 500,
    parameter int IRQ_MAX_US     = 1_000,
    parameter int UNPLUG_US      = 2_000,
    parameter int IRQ_SPACING_US = 2_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hpd_signal,
    output logic       hpd_detect,
    output logic       hpd_irq,
    output logic       hpd_irq_drop,
    output logic       hpd_unplug,
    output logic [1:0] hpd_state
);

    localparam longint PLUG_T    = us_to_ticks(CLK_FREQ, PLUG_US);
    localparam longint IRQ_MIN_T = us_to_ticks(CLK_FREQ, IRQ_MIN_US);
    localparam longint IRQ_MAX_T = us_to_ticks(CLK_FREQ, IRQ_MAX_US);
    localparam longint UNPLUG_T  = us_to_ticks(CLK_FREQ, UNPLUG_US);
    localparam longint SPC_T     = us_to_ticks(CLK_FREQ, IRQ_SPACING_US);

    localparam longint CNT_MAX = (PLUG_T > UNPLUG_T) ? PLUG_T : UNPLUG_T;
    localparam int     CNT_W   = $clog2(CNT_MAX + 1);
    localparam int     SPC_W   = (SPC_T < 1) ? 1 : $clog2(SPC_T + 1);

    // "cnt+1 reaches X" is evaluated as cnt >= X-1 to keep compares at counter width.
    localparam logic [CNT_W-1:0] PLUG_LIM  = CNT_W'((PLUG_T > 0) ? PLUG_T - 1 : 0);
    localparam logic [CNT_W-1:0] UNP_LIM   = CNT_W'(UNPLUG_T - 1);
    localparam logic [CNT_W-1:0] IRQ_MIN_C = CNT_W'(IRQ_MIN_T);
    localparam logic [CNT_W-1:0] IRQ_MAX_C = CNT_W'(IRQ_MAX_T);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [SPC_W-1:0] SPC_SAT   = SPC_W'(SPC_T);

    if (!(IRQ_MIN_T >= 1 && IRQ_MIN_T <= IRQ_MAX_T && IRQ_MAX_T < UNPLUG_T && SYNC_STAGES >= 2))
    begin : g_bad_params
        $error("hpd_monitor: invalid timing or synchroniser parameters");
    end

    logic             hpd_sync;
    hpd_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [SPC_W-1:0] spc, spc_nxt;
    logic             detect_nxt, irq_nxt, drop_nxt, unplug_nxt, spc_ok;

    hpd_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (hpd_signal),
        .level (hpd_sync)
    );

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    assign spc_ok  = (spc >= SPC_SAT);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        detect_nxt = hpd_detect;
        irq_nxt    = 1'b0;
        drop_nxt   = 1'b0;
        unplug_nxt = 1'b0;
        case (state)
            UNPLUGGED: if (hpd_sync) begin
                state_nxt = DEBOUNCE;
                cnt_nxt   = CNT_W'(1);
            end
            DEBOUNCE: begin
                if (!hpd_sync) state_nxt = UNPLUGGED;
                else if (cnt >= PLUG_LIM) begin
                    state_nxt  = CONNECTED;
                    detect_nxt = 1'b1;
                end else cnt_nxt = cnt_inc;
            end
            CONNECTED: if (!hpd_sync) begin
                state_nxt = LOW_MEASURE;
                cnt_nxt   = CNT_W'(1);
            end
            LOW_MEASURE: begin
                if (!hpd_sync) begin
                    if (cnt >= UNP_LIM) begin
                        state_nxt  = UNPLUGGED;
                        detect_nxt = 1'b0;
                        unplug_nxt = 1'b1;
                    end else cnt_nxt = cnt_inc;
                end else begin
                    // Pin came back: cnt is the completed low length.
                    state_nxt = CONNECTED;
                    if (cnt >= IRQ_MIN_C && cnt <= IRQ_MAX_C) begin
                        if (spc_ok) irq_nxt  = 1'b1;
                        else        drop_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = UNPLUGGED;
        endcase

        spc_nxt = spc;
        if (irq_nxt)            spc_nxt = SPC_W'(1);
        else if (spc < SPC_SAT) spc_nxt = spc + SPC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= UNPLUGGED;
            cnt          <= '0;
            spc          <= SPC_SAT;
            hpd_detect   <= 1'b0;
            hpd_irq      <= 1'b0;
            hpd_irq_drop <= 1'b0;
            hpd_unplug   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            spc          <= spc_nxt;
            hpd_detect   <= detect_nxt;
            hpd_irq      <= irq_nxt;
            hpd_irq_drop <= drop_nxt;
            hpd_unplug   <= unplug_nxt;
        end
    end

    assign hpd_state = state;

endmodule

// File: tb/tb_hpd_monitor.sv
// Scoreboard bench for hpd_monitor: a segment-level pin model predicts event
// kinds and cycles; a monitor pops and compares whenever the DUT emits one.
module tb_hpd_monitor;

    localparam int PLUG = 10000, IMIN = 50, IMAX = 100, UNP = 200, SPC = 200;
    localparam int K_CONN = 0, K_IRQ = 1, K_DROP = 2, K_UNP = 3;

    logic       clk = 1'b0, rst_n = 1'b0, hpd_signal = 1'b0;
    logic       hpd_detect, hpd_irq, hpd_irq_drop, hpd_unplug;
    logic [1:0] hpd_state;

    hpd_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hpd_signal   (hpd_signal),
        .hpd_detect   (hpd_detect),
        .hpd_irq      (hpd_irq),
        .hpd_irq_drop (hpd_irq_drop),
        .hpd_unplug   (hpd_unplug),
        .hpd_state    (hpd_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int t; } ev_t;
    ev_t sb[$];
    int  errors = 0, checks = 0;

    // Model state, tracked per pin segment
    bit m_conn = 0, m_pend = 0;
    int m_low = 0, m_last = -1;

    function automatic string kname(input int k);
        case (k)
            K_CONN:  return "connect";
            K_IRQ:   return "irq";
            K_DROP:  return "irq_drop";
            default: return "unplug";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int t);
        ev_t e;
        e.kind = k;
        e.t    = t;
        sb.push_back(e);
    endtask

    // Drive the pin at level v for n cycles; segments alternate in level.
    task automatic seg(input bit v, input int n);
        int s, d;
        s = cyc;
        if (v) begin
            if (m_conn && m_pend) begin
                d = s + 3;
                if (m_low >= IMIN && m_low <= IMAX) begin
                    if (m_last < 0 || d - m_last >= SPC) begin
                        push(K_IRQ, d);
                        m_last = d;
                    end else push(K_DROP, d);
                end
                m_pend = 0;
            end
            if (!m_conn && n >= PLUG) begin
                push(K_CONN, s + 2 + PLUG);
                m_conn = 1;
            end
        end else if (m_conn) begin
            if (n >= UNP) begin
                push(K_UNP, s + 2 + UNP);
                m_conn = 0;
            end else begin
                m_pend = 1;
                m_low  = n;
            end
        end
        hpd_signal = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic ev_check(input int k);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL event: got %s at cycle %0d, expected none", kname(k), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.t != cyc) begin
                errors++;
                $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                         kname(k), cyc, kname(e.kind), e.t);
            end
        end
    endtask

    bit prev_det = 0;
    always @(negedge clk) begin
        int npulse;
        if (!rst_n) prev_det = 0;
        else begin
            npulse = int'(hpd_irq) + int'(hpd_irq_drop) + int'(hpd_unplug);
            if (npulse > 0) chk("pulse_exclusive", npulse, 1);
            if (hpd_detect && !prev_det) ev_check(K_CONN);
            if (!hpd_detect && prev_det && !hpd_unplug) begin
                checks++;
                errors++;
                $display("FAIL detect_fall: got fall without unplug at cycle %0d, expected none", cyc);
            end
            if (hpd_irq)      ev_check(K_IRQ);
            if (hpd_irq_drop) ev_check(K_DROP);
            if (hpd_unplug) begin
                ev_check(K_UNP);
                chk("unplug_detect_low", int'(hpd_detect), 0);
            end
            prev_det = hpd_detect;
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_detect"}, int'(hpd_detect), 0);
        chk({tag, "_irq"},    int'(hpd_irq), 0);
        chk({tag, "_drop"},   int'(hpd_irq_drop), 0);
        chk({tag, "_unplug"}, int'(hpd_unplug), 0);
        chk({tag, "_state"},  int'(hpd_state), 0);
    endtask

    int lows[8] = '{49, 50, 51, 99, 100, 101, 198, 199};

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        // Plug one cycle short, then debounce glitch followed by a full plug
        seg(1, 9999);
        seg(0, 50);
        chk("short_plug_detect", int'(hpd_detect), 0);
        chk("short_plug_state", int'(hpd_state), 0);
        seg(1, 5000);
        seg(0, 1);
        seg(1, 10500);
        chk("plugged_state", int'(hpd_state), 2);

        // Width boundaries and the mid-range IRQ
        seg(0, 75);  seg(1, 300);
        seg(0, 49);  seg(1, 300);
        seg(0, 50);  seg(1, 300);
        seg(0, 100); seg(1, 300);
        seg(0, 101); seg(1, 300);
        seg(0, 199); seg(1, 300);
        chk("unqualified_detect", int'(hpd_detect), 1);

        // Spacing: rises 150 apart then 200 apart
        seg(0, 75); seg(1, 75);  seg(0, 75); seg(1, 300);
        seg(0, 75); seg(1, 125); seg(0, 75); seg(1, 300);

        // Unplug, reconnect, grant an IRQ, then reset mid-measurement
        seg(0, 200);
        seg(1, 10100);
        seg(0, 75); seg(1, 100);
        seg(0, 122);
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        m_conn = 0; m_pend = 0; m_last = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seg(1, 10100);
        seg(0, 75); seg(1, 300);

        // Randomised low excursions while connected
        for (int i = 0; i < 60; i++) begin
            int l;
            if ($urandom_range(3, 0) == 0) l = lows[$urandom_range(7, 0)];
            else                           l = int'($urandom_range(199, 1));
            seg(0, l);
            seg(1, int'($urandom_range(300, 20)));
        end
        seg(1, 400);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
